store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Write-side counterpart to immediate/operand extension: narrows a 32-bit register value to the byte lanes selected by SB, SH or SW.
- Produces lane-aligned write data plus byte enables, queues stores in a small FIFO, and drives them to data memory through a valid/ack handshake.
- Sits between the MEM stage and the data memory port.
- Misaligned stores are rejected and flagged as an address-error exception.

Parameters:
- DEPTH, 2, store FIFO entries; power of two, minimum 2.
- AW, 32, address width in bits.

Ports:
- clk_I  input  1  clock; rising edge.
- rst_I  input  1  synchronous, active-high reset.
- st_valid_I  input  1  store request present this cycle.
- st_ready_O  output  1  unit can accept a request this cycle.
- op_I  input  6  instruction opcode bits [31:26].
- addr_I  input  AW  effective byte address.
- data_I  input  32  rt register value.
- mem_valid_O  output  1  head entry presented to memory.
- mem_ack_I  input  1  memory accepts head entry this cycle.
- mem_addr_O  output  AW  word address of head entry; {addr[AW-1:2],2'b00}.
- mem_wdata_O  output  32  lane-aligned write data.
- mem_be_O  output  4  byte enables; bit n = byte lane n.
- exc_O  output  1  one-cycle address-error-store pulse.
- badvaddr_O  output  AW  faulting address; held until the next exception.
- empty_O  output  1  FIFO empty; no store outstanding.

Behaviour:
- Opcode decode: OP_SB=6'b101000, OP_SH=6'b101001, OP_SW=6'b101011.
  - Any other op with st_valid_I high is ignored: no enqueue, no exception.
- Lane mapping is little-endian; lane = addr_I[1:0].
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{data_I[7:0]}}.
  - SH: be = 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1; wdata = {2{data_I[15:0]}}.
  - SW: be = 4'b1111; wdata = data_I.
- Alignment check:
  - SH with addr[0]=1 is misaligned.
  - SW with addr[1:0]!=0 is misaligned.
  - SB is never misaligned.
- Accept condition: st_valid_I & st_ready_O & store op.
  - Aligned request: enqueue {word addr, wdata, be}.
  - Misaligned request: no enqueue. On the next cycle exc_O=1 for exactly one cycle and badvaddr_O=addr_I.
- st_ready_O = !full. It is computed from the registered count only; a same-cycle pop does not free a slot.
- Latency: an entry enqueued at edge N is visible on mem_valid_O/mem_* after edge N (earliest cycle N+1) when the FIFO was empty.
- Output handshake:
  - mem_valid_O = !empty.
  - Head is popped at an edge where mem_valid_O & mem_ack_I.
  - mem_* stay stable while mem_valid_O=1 and no ack.
  - mem_ack_I is ignored when empty.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- FIFO ordering is strict: stores retire in program order.
- empty_O = (count==0); the pipeline uses it to order loads behind pending stores.
- Reset (rst_I high at an edge, including mid-transfer):
  - count, pointers = 0; pending entries discarded.
  - mem_valid_O=0, exc_O=0, badvaddr_O=0, empty_O=1.
  - st_ready_O=1 on the first cycle after reset.
  - mem_wdata_O, mem_be_O, mem_addr_O are 0 while empty.
- Reset overrides a same-edge accept or ack.

Test Plan:
- SB addr=0x1003, data=0xAABBCCDD, mem_ack_I=1 -> next cycle mem_valid_O=1, mem_addr_O=0x1000, be=4'b1000, wdata=0xDDDDDDDD; popped the following edge; empty_O=1 after.
- SH addr=0x2002, data=0x12345678 -> be=4'b1100, wdata=0x56785678. SH addr=0x2001 -> no enqueue, exc_O pulses 1 cycle, badvaddr_O=0x2001.
- SW addr=0x3004, data=0xDEADBEEF -> be=4'b1111, wdata=0xDEADBEEF. SW addr=0x3006 -> exc_O pulse, empty_O stays 1.
- mem_ack_I=0 while issuing 3 SW (DEPTH=2) -> st_ready_O=0 after 2 accepts, third held off. Raise ack -> entries drain in order; third accepted once st_ready_O=1.
- Continuous push with ack every cycle over 8 stores -> pointer wrap; all 8 retire in order with correct data; count never exceeds 2.
- Fill FIFO with 2 entries, assert rst_I for one edge during mem_valid_O -> mem_valid_O=0, empty_O=1, st_ready_O=1; no stale entry appears afterwards.

Source files
------------

// File: rtl/store_unit.sv
// store_unit: narrows a 32-bit register value to the SB/SH/SW byte lanes and
// produces lane-aligned write data and byte enables. Aligned stores are queued
// in a small in-order FIFO and presented to data memory over a valid/ack
// handshake. Misaligned stores are dropped and raise a one-cycle address-error
// pulse that also captures the faulting address.
//
// Ports:
//   clk_I, rst_I          clock (rising edge), synchronous active-high reset
//   st_valid_I/st_ready_O store request / unit can accept (FIFO not full)
//   op_I, addr_I, data_I  opcode[31:26], effective byte address, rt value
//   mem_valid_O/mem_ack_I head entry presented / accepted by memory
//   mem_addr_O            word address of head entry
//   mem_wdata_O, mem_be_O lane-aligned write data, byte enables
//   exc_O, badvaddr_O     address-error pulse, last faulting address
//   empty_O               no store outstanding

package store_unit_pkg;

   // Per-entry write payload; the address is stored separately because its
   // width is a module parameter.
   typedef struct packed {
      logic [31:0] wdata;
      logic [3:0]  be;
   } st_payload_t;

endpackage

module store_unit
   import store_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = 32
) (
   input  logic          clk_I,
   input  logic          rst_I,
   input  logic          st_valid_I,
   output logic          st_ready_O,
   input  logic [5:0]    op_I,
   input  logic [AW-1:0] addr_I,
   input  logic [31:0]   data_I,
   output logic          mem_valid_O,
   input  logic          mem_ack_I,
   output logic [AW-1:0] mem_addr_O,
   output logic [31:0]   mem_wdata_O,
   output logic [3:0]    mem_be_O,
   output logic          exc_O,
   output logic [AW-1:0] badvaddr_O,
   output logic          empty_O
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [5:0] OP_SB = 6'b101000;
   localparam logic [5:0] OP_SH = 6'b101001;
   localparam logic [5:0] OP_SW = 6'b101011;

   st_payload_t   payload_q [DEPTH];
   logic [AW-1:0] addr_q    [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic        is_store;
   logic        misaligned;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic        accept;
   logic        push;
   logic        pop;

   // Opcode decode, lane mapping and alignment check.
   always_comb begin
      is_store   = 1'b0;
      misaligned = 1'b0;
      be_c       = 4'b0000;
      wdata_c    = 32'h0;
      case (op_I)
         OP_SB: begin
            is_store = 1'b1;
            be_c     = 4'b0001 << addr_I[1:0];
            wdata_c  = {4{data_I[7:0]}};
         end
         OP_SH: begin
            is_store   = 1'b1;
            misaligned = addr_I[0];
            be_c       = addr_I[1] ? 4'b1100 : 4'b0011;
            wdata_c    = {2{data_I[15:0]}};
         end
         OP_SW: begin
            is_store   = 1'b1;
            misaligned = (addr_I[1:0] != 2'b00);
            be_c       = 4'b1111;
            wdata_c    = data_I;
         end
         default: ;
      endcase
   end

   // Ready depends on the registered count only, so a same-cycle pop never
   // opens a slot for the incoming request.
   assign st_ready_O  = (count != CW'(DEPTH));
   assign empty_O     = (count == '0);
   assign mem_valid_O = !empty_O;

   assign accept = st_valid_I & st_ready_O & is_store;
   assign push   = accept & !misaligned;
   assign pop    = mem_valid_O & mem_ack_I;

   // Head entry; forced to zero while empty so stale storage never shows.
   assign mem_addr_O  = empty_O ? '0    : addr_q[rd_ptr];
   assign mem_wdata_O = empty_O ? 32'h0 : payload_q[rd_ptr].wdata;
   assign mem_be_O    = empty_O ? 4'h0  : payload_q[rd_ptr].be;

   // Entry storage; needs no reset since count gates visibility.
   always_ff @(posedge clk_I) begin
      if (push) begin
         addr_q[wr_ptr]          <= {addr_I[AW-1:2], 2'b00};
         payload_q[wr_ptr].wdata <= wdata_c;
         payload_q[wr_ptr].be    <= be_c;
      end
   end

   // Pointers, occupancy and exception reporting.
   always_ff @(posedge clk_I) begin
      if (rst_I) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         exc_O      <= 1'b0;
         badvaddr_O <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         exc_O <= accept & misaligned;
         if (accept & misaligned) begin
            badvaddr_O <= addr_I;
         end
      end
   end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed and randomized stimulus for store_unit, checked
// against a queue-based reference model of the store FIFO.
module tb_store_unit;

   localparam int DEPTH = 2;
   localparam int AW    = 32;

   localparam logic [5:0] OP_SB = 6'b101000;
   localparam logic [5:0] OP_SH = 6'b101001;
   localparam logic [5:0] OP_SW = 6'b101011;
   localparam logic [5:0] OP_LW = 6'b100011;

   logic          clk;
   logic          rst;
   logic          st_valid;
   logic          st_ready;
   logic [5:0]    op;
   logic [AW-1:0] addr;
   logic [31:0]   data;
   logic          mem_valid;
   logic          mem_ack;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic          exc;
   logic [AW-1:0] badvaddr;
   logic          empty;

   store_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk_I       (clk),
      .rst_I       (rst),
      .st_valid_I  (st_valid),
      .st_ready_O  (st_ready),
      .op_I        (op),
      .addr_I      (addr),
      .data_I      (data),
      .mem_valid_O (mem_valid),
      .mem_ack_I   (mem_ack),
      .mem_addr_O  (mem_addr),
      .mem_wdata_O (mem_wdata),
      .mem_be_O    (mem_be),
      .exc_O       (exc),
      .badvaddr_O  (badvaddr),
      .empty_O     (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } ent_t;

   ent_t          q[$];
   logic          exp_exc;
   logic [31:0]   exp_badv;
   bit            last_acc;
   int            checks   = 0;
   int            failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs mid-cycle, then advance the model across the edge.
   task automatic tick();
      int   sz;
      bit   rdy, do_pop, acc, mis;
      ent_t e;
      @(negedge clk);
      chk("empty", 64'(empty), 64'(q.size() == 0));
      chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
      chk("st_ready", 64'(st_ready), 64'(q.size() < DEPTH));
      chk("exc", 64'(exc), 64'(exp_exc));
      chk("badvaddr", 64'(badvaddr), 64'(exp_badv));
      if (q.size() != 0) begin
         chk("mem_addr", 64'(mem_addr), 64'(q[0].a));
         chk("mem_wdata", 64'(mem_wdata), 64'(q[0].d));
         chk("mem_be", 64'(mem_be), 64'(q[0].be));
      end else begin
         chk("mem_addr_idle", 64'(mem_addr), 64'(0));
         chk("mem_wdata_idle", 64'(mem_wdata), 64'(0));
         chk("mem_be_idle", 64'(mem_be), 64'(0));
      end
      sz = (op == OP_SB) ? 1 : (op == OP_SH) ? 2 : (op == OP_SW) ? 4 : 0;
      rdy    = q.size() < DEPTH;
      do_pop = (q.size() != 0) && mem_ack;
      acc    = st_valid && rdy && (sz != 0);
      mis    = acc && ((addr % sz) != 0);
      e.a    = addr - (addr % 4);
      e.be   = 4'((2 ** sz - 1) << (addr % 4));
      e.d    = (sz == 1) ? data[7:0] * 32'h0101_0101 :
               (sz == 2) ? data[15:0] * 32'h0001_0001 : data;
      @(posedge clk);
      #1;
      last_acc = 1'b0;
      if (rst) begin
         q.delete();
         exp_exc  = 1'b0;
         exp_badv = 32'h0;
      end else begin
         last_acc = acc;
         if (do_pop) void'(q.pop_front());
         if (acc && !mis) q.push_back(e);
         exp_exc = mis;
         if (mis) exp_badv = addr;
      end
   endtask

   // Present a request and hold it until the model records acceptance.
   task automatic send(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d);
      int n;
      op = o; addr = a; data = d; st_valid = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 20);
      if (!last_acc) chk("send_timeout", 64'(0), 64'(1));
   endtask

   initial begin
      rst = 1'b1; st_valid = 1'b0; op = 6'h0; addr = '0; data = '0; mem_ack = 1'b0;
      exp_exc = 1'b0; exp_badv = 32'h0; last_acc = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // SB into the top lane, acked immediately
      mem_ack = 1'b1;
      send(OP_SB, 32'h1003, 32'hAABB_CCDD);
      st_valid = 1'b0;
      chk("sb_be_direct", 64'(mem_be), 64'(4'b1000));
      chk("sb_wdata_direct", 64'(mem_wdata), 64'(32'hDDDD_DDDD));
      tick();
      tick();

      // SH upper half, then misaligned SH
      mem_ack = 1'b0;
      send(OP_SH, 32'h2002, 32'h1234_5678);
      st_valid = 1'b0;
      chk("sh_wdata_direct", 64'(mem_wdata), 64'(32'h5678_5678));
      tick();
      mem_ack = 1'b1;
      tick();
      send(OP_SH, 32'h2001, 32'h1234_5678);
      st_valid = 1'b0;
      chk("sh_mis_exc", 64'(exc), 64'(1));
      chk("sh_mis_badv", 64'(badvaddr), 64'(32'h2001));
      tick();
      tick();

      // SW aligned and misaligned
      send(OP_SW, 32'h3004, 32'hDEAD_BEEF);
      st_valid = 1'b0;
      tick();
      send(OP_SW, 32'h3006, 32'hDEAD_BEEF);
      st_valid = 1'b0;
      chk("sw_mis_empty", 64'(empty), 64'(1));
      tick();

      // Back-pressure: third SW held off while full
      mem_ack = 1'b0;
      send(OP_SW, 32'h4000, 32'h1111_1111);
      send(OP_SW, 32'h4004, 32'h2222_2222);
      op = OP_SW; addr = 32'h4008; data = 32'h3333_3333;
      repeat (3) tick();
      chk("full_not_ready", 64'(st_ready), 64'(0));
      mem_ack = 1'b1;
      send(OP_SW, 32'h4008, 32'h3333_3333);
      st_valid = 1'b0;
      repeat (4) tick();

      // Eight back-to-back stores with ack every cycle
      for (int i = 0; i < 8; i++) begin
         send(OP_SW, 32'h5000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
      end
      st_valid = 1'b0;
      repeat (3) tick();

      // Reset while entries are pending
      mem_ack = 1'b0;
      send(OP_SW, 32'h6000, 32'hAAAA_0001);
      send(OP_SB, 32'h6001, 32'hAAAA_0002);
      st_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_ack = 1'b1;
      repeat (3) tick();

      // Randomized traffic including non-store ops and occasional reset
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: op = OP_SB;
            1: op = OP_SH;
            2: op = OP_SW;
            default: op = OP_LW;
         endcase
         addr     = $urandom;
         data     = $urandom;
         st_valid = ($urandom_range(0, 3) != 0);
         mem_ack  = ($urandom_range(0, 2) != 0);
         rst      = ($urandom_range(0, 60) == 0);
         tick();
      end
      rst = 1'b0; st_valid = 1'b0; mem_ack = 1'b1;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
